// File: rtl/dsm_cfg_master_if.sv
// Host command channel, matrix configuration port, status and readback
// signals of the crosspoint-matrix configuration master.
//
//   cmd_valid/cmd_ready/cmd_op/cmd_in/cmd_out : host command handshake
//   dsm_cs/dsm_cnfg/dsm_load/dsm_res           : matrix control strobes
//   dsm_in_add/dsm_out_add                     : matrix address lines
//   busy/done/pending                          : status
//   rd_out/rd_in                               : active-table readback
//
// modport master : the configuration master (drives matrix port and status)
// modport slave  : host / matrix side (drives commands and readback index)
interface dsm_cfg_master_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned OP_W   = 2;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_in;
  logic [ADDR_W-1:0] cmd_out;

  logic              dsm_cs;
  logic              dsm_cnfg;
  logic              dsm_load;
  logic              dsm_res;
  logic [ADDR_W-1:0] dsm_in_add;
  logic [ADDR_W-1:0] dsm_out_add;

  logic              busy;
  logic              done;
  logic              pending;

  logic [ADDR_W-1:0] rd_out;
  logic [ADDR_W-1:0] rd_in;

  modport master (
    input  cmd_valid, cmd_op, cmd_in, cmd_out, rd_out,
    output cmd_ready, dsm_cs, dsm_cnfg, dsm_load, dsm_res,
           dsm_in_add, dsm_out_add, busy, done, pending, rd_in
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_in, cmd_out, rd_out,
    input  cmd_ready, dsm_cs, dsm_cnfg, dsm_load, dsm_res,
           dsm_in_add, dsm_out_add, busy, done, pending, rd_in
  );
endinterface

// File: rtl/dsm_cfg_master.sv
// Crosspoint matrix configuration master.
// Buffers host ROUTE/COMMIT/CLEAR/NOP commands in a FIFO and plays each one
// out on the matrix port as SETUP -> STROBE (STROBE_CYC cycles) -> HOLD.
// Shadow copies of the staged and active routing tables are kept for readback.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : dsm_cfg_master_if.master (command channel, matrix port, status,
//          readback; rd_in = active[rd_out] is combinational)
module dsm_cfg_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dsm_cfg_master_if.master       bus
);

  localparam int unsigned AW    = 4;
  localparam int unsigned OPW   = 2;
  localparam int unsigned NOUT  = 16;
  localparam int unsigned IW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = IW + 1;
  localparam int unsigned CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  localparam logic [OPW-1:0]   OP_ROUTE  = 2'b00;
  localparam logic [OPW-1:0]   OP_COMMIT = 2'b01;
  localparam logic [OPW-1:0]   OP_CLEAR  = 2'b10;
  localparam logic [OPW-1:0]   OP_NOP    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STROBE_CYC - 1);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  src;
    logic [AW-1:0]  dst;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_e;

  // Command FIFO
  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  // FSM and registered outputs
  state_e         state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  cmd_t           cur_q,     cur_d;
  logic           cs_q,      cs_d;
  logic           cnfg_q,    cnfg_d;
  logic           load_q,    load_d;
  logic           res_q,     res_d;
  logic           done_q,    done_d;
  logic [AW-1:0]  in_add_q,  in_add_d;
  logic [AW-1:0]  out_add_q, out_add_d;

  // Shadow routing tables
  logic [AW-1:0]  staged_q [NOUT];
  logic [AW-1:0]  active_q [NOUT];
  logic           pending_q;

  // Strobe selection for the command currently in flight
  logic           is_route;
  logic           is_commit;
  logic           is_clear;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.cmd_valid & ~full;
  assign head  = mem[rd_ptr_q[IW-1:0]];

  assign is_route  = (cur_q.op == OP_ROUTE);
  assign is_commit = (cur_q.op == OP_COMMIT);
  assign is_clear  = (cur_q.op == OP_CLEAR);

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[IW-1:0]] <= cmd_t'({bus.cmd_op, bus.cmd_in, bus.cmd_out});
    end
  end

  // FIFO pointers, wrapping modulo 2*FIFO_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      cs_q      <= 1'b0;
      cnfg_q    <= 1'b0;
      load_q    <= 1'b0;
      res_q     <= 1'b0;
      done_q    <= 1'b0;
      in_add_q  <= '0;
      out_add_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      cs_q      <= cs_d;
      cnfg_q    <= cnfg_d;
      load_q    <= load_d;
      res_q     <= res_d;
      done_q    <= done_d;
      in_add_q  <= in_add_d;
      out_add_q <= out_add_d;
    end
  end

  // Next state plus next value of every registered port output, so the
  // outputs line up with the state they belong to without decode glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    pop       = 1'b0;
    cs_d      = 1'b0;
    cnfg_d    = 1'b0;
    load_d    = 1'b0;
    res_d     = 1'b0;
    done_d    = 1'b0;
    in_add_d  = '0;
    out_add_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // NOP is simply dropped; IDLE can pop again next cycle
          if (head.op != OP_NOP) begin
            state_d = ST_SETUP;
            cur_d   = head;
            if (head.op == OP_ROUTE) begin
              in_add_d  = head.src;
              out_add_d = head.dst;
            end
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_STROBE;
        cnt_d     = '0;
        in_add_d  = in_add_q;
        out_add_d = out_add_q;
        cs_d      = 1'b1;
        cnfg_d    = is_route;
        load_d    = is_commit;
        res_d     = is_clear;
      end

      ST_STROBE: begin
        in_add_d  = in_add_q;
        out_add_d = out_add_q;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          cs_d   = 1'b1;
          cnfg_d = is_route;
          load_d = is_commit;
          res_d  = is_clear;
        end
      end

      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shadow tables update on the SETUP -> STROBE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NOUT; i++) begin
        staged_q[AW'(i)] <= '0;
        active_q[AW'(i)] <= '0;
      end
      pending_q <= 1'b0;
    end else if (state_q == ST_SETUP) begin
      if (is_route) begin
        staged_q[cur_q.dst] <= cur_q.src;
        pending_q           <= 1'b1;
      end else if (is_commit) begin
        for (int unsigned i = 0; i < NOUT; i++) begin
          active_q[AW'(i)] <= staged_q[AW'(i)];
        end
        pending_q <= 1'b0;
      end else if (is_clear) begin
        for (int unsigned i = 0; i < NOUT; i++) begin
          staged_q[AW'(i)] <= '0;
          active_q[AW'(i)] <= '0;
        end
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready   = ~full;
  assign bus.dsm_cs      = cs_q;
  assign bus.dsm_cnfg    = cnfg_q;
  assign bus.dsm_load    = load_q;
  assign bus.dsm_res     = res_q;
  assign bus.dsm_in_add  = in_add_q;
  assign bus.dsm_out_add = out_add_q;
  assign bus.done        = done_q;
  assign bus.pending     = pending_q;
  assign bus.busy        = (state_q != ST_IDLE) | ~empty;
  assign bus.rd_in       = active_q[bus.rd_out];

endmodule

// File: tb/tb_dsm_cfg_master.sv
// Directed bench for dsm_cfg_master: command timing on the matrix port,
// FIFO back-pressure and ordering, shadow tables, NOP handling and reset
// in the middle of a strobe.
module tb_dsm_cfg_master;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned STROBE_CYC = 2;

  localparam logic [1:0] OP_ROUTE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  logic clk;
  logic rst;

  dsm_cfg_master_if bus ();

  dsm_cfg_master #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .STROBE_CYC(STROBE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strb();
    return {bus.dsm_cs, bus.dsm_cnfg, bus.dsm_load, bus.dsm_res};
  endfunction

  // {cs, cnfg, load, res} while a command is strobing
  function automatic logic [3:0] exp_strb(input logic [1:0] op);
    case (op)
      OP_ROUTE:  return 4'b1100;
      OP_COMMIT: return 4'b1010;
      OP_CLEAR:  return 4'b1001;
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_in    = src;
    bus.cmd_out   = dst;
  endtask

  task automatic push_one(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input string tag);
    chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    drive(op, src, dst);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Starts at the IDLE cycle in which the command is the FIFO head
  task automatic observe(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input string tag);
    logic [3:0] ea_in;
    logic [3:0] ea_out;
    ea_in  = (op == OP_ROUTE) ? src : 4'd0;
    ea_out = (op == OP_ROUTE) ? dst : 4'd0;
    tick();
    chk({tag, ".setup_strb"}, 32'(strb()), 32'd0);
    chk({tag, ".setup_in"},   32'(bus.dsm_in_add),  32'(ea_in));
    chk({tag, ".setup_out"},  32'(bus.dsm_out_add), 32'(ea_out));
    for (int k = 0; k < int'(STROBE_CYC); k++) begin
      tick();
      chk({tag, ".strobe"},     32'(strb()), 32'(exp_strb(op)));
      chk({tag, ".strobe_in"},  32'(bus.dsm_in_add),  32'(ea_in));
      chk({tag, ".strobe_out"}, 32'(bus.dsm_out_add), 32'(ea_out));
      chk({tag, ".strobe_done"}, 32'(bus.done), 32'd0);
    end
    tick();
    chk({tag, ".hold_strb"}, 32'(strb()), 32'd0);
    chk({tag, ".hold_done"}, 32'(bus.done), 32'd1);
    chk({tag, ".hold_in"},   32'(bus.dsm_in_add),  32'(ea_in));
    chk({tag, ".hold_out"},  32'(bus.dsm_out_add), 32'(ea_out));
    tick();
    chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle_addr"}, 32'({bus.dsm_in_add, bus.dsm_out_add}), 32'd0);
  endtask

  task automatic exec(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                      input string tag);
    push_one(op, src, dst, tag);
    chk({tag, ".pop_strb"}, 32'(strb()), 32'd0);
    chk({tag, ".pop_busy"}, 32'(bus.busy), 32'd1);
    observe(op, src, dst, tag);
  endtask

  task automatic rd_chk(input logic [3:0] idx, input logic [3:0] exp, input string tag);
    bus.rd_out = idx;
    #1;
    chk(tag, 32'(bus.rd_in), 32'(exp));
  endtask

  // Back-to-back burst stimulus and expectations
  logic [1:0] b_op  [6] = '{OP_ROUTE, OP_ROUTE, OP_COMMIT, OP_ROUTE, OP_ROUTE, OP_COMMIT};
  logic [3:0] b_src [6] = '{4'd1, 4'd4, 4'd0, 4'd8, 4'd9, 4'd0};
  logic [3:0] b_dst [6] = '{4'd2, 4'd3, 4'd0, 4'd15, 4'd15, 4'd0};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          stalls;
    int          nd;
    int          ns;
    int          done_cyc [8];
    logic [10:0] sig_obs  [8];
    logic [10:0] sig_exp;
    logic [3:0]  es;
    logic        prev_cs;
    logic        seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_in    = '0;
    bus.cmd_out   = '0;
    bus.rd_out    = '0;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst.strb",    32'(strb()), 32'd0);
    chk("rst.addr",    32'({bus.dsm_in_add, bus.dsm_out_add}), 32'd0);
    chk("rst.busy",    32'(bus.busy), 32'd0);
    chk("rst.done",    32'(bus.done), 32'd0);
    chk("rst.pending", 32'(bus.pending), 32'd0);
    chk("rst.ready",   32'(bus.cmd_ready), 32'd1);
    rd_chk(4'd9, 4'd0, "rst.rd_in");

    // Single ROUTE, then COMMIT
    exec(OP_ROUTE, 4'd5, 4'd9, "t1");
    chk("t1.pending", 32'(bus.pending), 32'd1);
    rd_chk(4'd9, 4'd0, "t1.rd_in");
    exec(OP_COMMIT, 4'd0, 4'd0, "t2");
    chk("t2.pending", 32'(bus.pending), 32'd0);
    rd_chk(4'd9, 4'd5, "t2.rd_in");

    // Six commands back-to-back against a depth-4 FIFO
    stalls = 0;
    nd     = 0;
    ns     = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          drive(b_op[i], b_src[i], b_dst[i]);
          if (i == 4) chk("t3.ready_3q", 32'(bus.cmd_ready), 32'd1);
          if (i == 5) chk("t3.ready_full", 32'(bus.cmd_ready), 32'd0);
          while (!bus.cmd_ready && stalls < 50) begin
            tick();
            stalls++;
          end
          tick();
        end
        bus.cmd_valid = 1'b0;
      end
      begin
        prev_cs = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
          tick();
          if (bus.done && nd < 8) begin
            done_cyc[nd] = cyc;
            nd++;
          end
          if (bus.dsm_cs && !prev_cs && ns < 8) begin
            sig_obs[ns] = {bus.dsm_cnfg, bus.dsm_load, bus.dsm_res,
                           bus.dsm_in_add, bus.dsm_out_add};
            ns++;
          end
          prev_cs = bus.dsm_cs;
        end
      end
    join
    chk("t3.stalls",  32'(stalls), 32'd2);
    chk("t3.n_done",  32'(nd), 32'd6);
    chk("t3.n_strb",  32'(ns), 32'd6);
    chk("t3.first_done", 32'(done_cyc[0]), 32'd5);
    for (int j = 1; j < nd && j < 6; j++) begin
      chk("t3.done_gap", 32'(done_cyc[j] - done_cyc[j-1]), 32'd5);
    end
    for (int j = 0; j < ns && j < 6; j++) begin
      es      = exp_strb(b_op[j]);
      sig_exp = {es[2:0],
                 (b_op[j] == OP_ROUTE) ? b_src[j] : 4'd0,
                 (b_op[j] == OP_ROUTE) ? b_dst[j] : 4'd0};
      chk("t3.order", 32'(sig_obs[j]), 32'(sig_exp));
    end
    chk("t3.pending", 32'(bus.pending), 32'd0);
    rd_chk(4'd2,  4'd1, "t3.rd2");
    rd_chk(4'd3,  4'd4, "t3.rd3");
    rd_chk(4'd15, 4'd9, "t3.rd15");

    // Overwrite, commit, then clear
    exec(OP_ROUTE,  4'd3, 4'd0, "t4a");
    exec(OP_ROUTE,  4'd7, 4'd0, "t4b");
    exec(OP_COMMIT, 4'd0, 4'd0, "t4c");
    rd_chk(4'd0, 4'd7, "t4.rd0");
    exec(OP_ROUTE, 4'd5, 4'd1, "t4d");
    chk("t4.pending_set", 32'(bus.pending), 32'd1);
    exec(OP_CLEAR, 4'd0, 4'd0, "t4e");
    chk("t4.pending_clr", 32'(bus.pending), 32'd0);
    for (int o = 0; o < 16; o++) begin
      rd_chk(4'(o), 4'd0, "t4.cleared");
    end
    exec(OP_COMMIT, 4'd0, 4'd0, "t4f");
    rd_chk(4'd1, 4'd0, "t4.staged_cleared");

    // NOP alone, then NOP immediately followed by ROUTE
    push_one(OP_NOP, 4'd0, 4'd0, "t5a");
    chk("t5a.busy_q", 32'(bus.busy), 32'd1);
    tick();
    chk("t5a.busy",  32'(bus.busy), 32'd0);
    chk("t5a.strb",  32'(strb()), 32'd0);
    chk("t5a.done",  32'(bus.done), 32'd0);
    drive(OP_NOP, 4'd0, 4'd0);
    tick();
    drive(OP_ROUTE, 4'd6, 4'd10);
    chk("t5b.nop_strb", 32'(strb()), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t5b.nop_strb2", 32'(strb()), 32'd0);
    chk("t5b.nop_done",  32'(bus.done), 32'd0);
    chk("t5b.nop_addr",  32'({bus.dsm_in_add, bus.dsm_out_add}), 32'd0);
    chk("t5b.busy",      32'(bus.busy), 32'd1);
    observe(OP_ROUTE, 4'd6, 4'd10, "t5b");
    chk("t5b.pending", 32'(bus.pending), 32'd1);

    // Reset during the strobe of a COMMIT with another command queued
    exec(OP_ROUTE, 4'd2, 4'd4, "t6a");
    drive(OP_COMMIT, 4'd0, 4'd0);
    tick();
    drive(OP_ROUTE, 4'd1, 4'd1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("t6.load_strb", 32'(strb()), 32'b1010);
    rd_chk(4'd4, 4'd2, "t6.committed");
    #2;
    rst = 1'b1;
    #1;
    chk("t6.rst_strb",    32'(strb()), 32'd0);
    chk("t6.rst_ready",   32'(bus.cmd_ready), 32'd1);
    chk("t6.rst_busy",    32'(bus.busy), 32'd0);
    chk("t6.rst_pending", 32'(bus.pending), 32'd0);
    chk("t6.rst_addr",    32'({bus.dsm_in_add, bus.dsm_out_add}), 32'd0);
    rd_chk(4'd4, 4'd0, "t6.rst_table");
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (strb() != 4'd0 || bus.done || bus.busy) seen = 1'b1;
    end
    chk("t6.fifo_lost", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
